// File: rtl/conv_deser_pkg.sv
// rtl/conv_deser_pkg.sv - shared types and constants for the serial-to-parallel deserializer
package conv_deser_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } deser_state_t;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hB8;

    localparam int BIT_CNT_W    = 3;
    localparam int WORD_CNT_W   = 8;
    localparam int VERIFY_CNT_W = 4;
    localparam int MISS_CNT_W   = 4;

endpackage

// File: rtl/conv_deser_align_fsm.sv
// rtl/conv_deser_align_fsm.sv - word/frame alignment, lock verification and miss tracking
module conv_deser_align_fsm
    import conv_deser_pkg::*;
#(
    parameter int FRAME_WORDS  = 16,
    parameter int VERIFY_COUNT = 2,
    parameter int MISS_LIMIT   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sync_match,
    output deser_state_t state,
    output logic         data_en,
    output logic         sync_en,
    output logic         err_en
);

    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [WORD_CNT_W-1:0]   word_cnt;
    logic [VERIFY_CNT_W-1:0] verify_cnt;
    logic [MISS_CNT_W-1:0]   miss_cnt;
    logic [WORD_CNT_W-1:0]   word_next;
    logic                    word_done;
    logic                    slot0;

    // Word boundaries only exist once a sync word has fixed the bit phase
    always_comb begin
        word_done = (state != ST_HUNT) && (bit_cnt == BIT_CNT_W'(7));
        slot0     = (word_cnt == '0);
        word_next = (word_cnt == WORD_CNT_W'(FRAME_WORDS - 1)) ? '0 : word_cnt + WORD_CNT_W'(1);
        data_en   = word_done && (state == ST_LOCKED) && !slot0;
        sync_en   = word_done && (state == ST_LOCKED) && slot0 && sync_match;
        err_en    = word_done && (state == ST_LOCKED) && slot0 && !sync_match;
    end

    // Alignment state machine with bit, word, verify and miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            verify_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                ST_HUNT: begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    if (sync_match) begin
                        // The matching bits were the sync slot, so the next bit starts slot 1
                        word_cnt   <= WORD_CNT_W'(1);
                        verify_cnt <= '0;
                        state      <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    if (word_done) begin
                        word_cnt <= word_next;
                        if (slot0) begin
                            if (!sync_match) begin
                                state <= ST_HUNT;
                            end else if (verify_cnt + VERIFY_CNT_W'(1) == VERIFY_CNT_W'(VERIFY_COUNT)) begin
                                miss_cnt <= '0;
                                state    <= ST_LOCKED;
                            end else begin
                                verify_cnt <= verify_cnt + VERIFY_CNT_W'(1);
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    if (word_done) begin
                        word_cnt <= word_next;
                        if (slot0 && sync_match) begin
                            miss_cnt <= '0;
                        end else if (slot0) begin
                            miss_cnt <= miss_cnt + MISS_CNT_W'(1);
                            if (miss_cnt + MISS_CNT_W'(1) == MISS_CNT_W'(MISS_LIMIT)) begin
                                state <= ST_HUNT;
                            end
                        end
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

endmodule

// File: rtl/conv_tree_deserializer.sv
// rtl/conv_tree_deserializer.sv - rebuilds framed 8-bit words from the serializer tree bit stream
module conv_tree_deserializer
    import conv_deser_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD    = DEFAULT_SYNC_WORD,
    parameter int               FRAME_WORDS  = 16,
    parameter int               VERIFY_COUNT = 2,
    parameter int               MISS_LIMIT   = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             SERIAL_IN,
    output logic [WIDTH-1:0] PAR_OUT,
    output logic             PAR_VALID,
    output logic             SYNC_PULSE,
    output logic             ALIGN_ERR,
    output logic             LOCKED
);

    // Only the seven oldest bits need storing; the newest comes straight from SERIAL_IN
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] w;
    logic             sync_match;
    deser_state_t     state;
    logic             data_en;
    logic             sync_en;
    logic             err_en;

    // Candidate word is the eight most recent bits, first-received in the MSB
    always_comb begin
        w          = {sr, SERIAL_IN};
        sync_match = (w == SYNC_WORD);
    end

    // Serial shift register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sr <= '0;
        end else begin
            sr <= w[WIDTH-2:0];
        end
    end

    conv_deser_align_fsm #(
        .FRAME_WORDS  (FRAME_WORDS),
        .VERIFY_COUNT (VERIFY_COUNT),
        .MISS_LIMIT   (MISS_LIMIT)
    ) u_align_fsm (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .sync_match (sync_match),
        .state      (state),
        .data_en    (data_en),
        .sync_en    (sync_en),
        .err_en     (err_en)
    );

    // Registered data word and one-cycle strobes
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PAR_OUT    <= '0;
            PAR_VALID  <= 1'b0;
            SYNC_PULSE <= 1'b0;
            ALIGN_ERR  <= 1'b0;
        end else begin
            PAR_VALID  <= data_en;
            SYNC_PULSE <= sync_en;
            ALIGN_ERR  <= err_en;
            if (data_en) begin
                PAR_OUT <= w;
            end
        end
    end

    assign LOCKED = (state == ST_LOCKED);

endmodule
